ins_loader: RTL and testbench

Manual instruction loader for the single-clock MIPS board. Assembles 32-bit instruction words from four 8-bit switch entries, each confirmed by a one-cycle button strobe from the button conditioner. Writes each completed word into instruction memory through a WE/ACK handshake, with an auto-incrementing word address. It is the input-side counterpart of the board's display path: it drives the core's `WE`/`W_Ins` write port instead of reading results out.

---
 rtl/ins_loader_if.sv | 27 ++
 rtl/ins_loader.sv | 107 ++++++++++
 tb/tb_ins_loader.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ins_loader_if.sv
// Bus between the manual instruction loader and its surroundings: switch/button
// inputs on one side, the instruction-memory write port and status on the other.
interface ins_loader_if #(
    parameter int ADDR_W = 8
);
    logic              LOAD_EN;
    logic [7:0]        BIN;
    logic              BSTB;
    logic              BUNDO;
    logic              W_ACK;
    logic              WE;
    logic [31:0]       W_Ins;
    logic [ADDR_W-1:0] W_Addr;
    logic [1:0]        BCNT;
    logic              BUSY;
    logic              OVF;

    modport master (
        output LOAD_EN, BIN, BSTB, BUNDO, W_ACK,
        input  WE, W_Ins, W_Addr, BCNT, BUSY, OVF
    );

    modport slave (
        input  LOAD_EN, BIN, BSTB, BUNDO, W_ACK,
        output WE, W_Ins, W_Addr, BCNT, BUSY, OVF
    );
endinterface

// File: rtl/ins_loader.sv
// Manual instruction loader: builds 32-bit words MSB-first from four switch bytes
// and writes each one to instruction memory via a WE/ACK handshake.
module ins_loader #(
    parameter int ADDR_W = 8
) (
    input  logic         CLK,
    input  logic         RST,
    ins_loader_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, COLLECT, WRITE} state_t;

    state_t            state_q, state_d;
    logic              we_q, we_d;
    logic              busy_q, busy_d;
    logic              ovf_q, ovf_d;
    logic [1:0]        bcnt_q, bcnt_d;
    logic [31:0]       ins_q, ins_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge value of every other register regardless of block order.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
            bcnt_q  <= 2'd0;
            ins_q   <= 32'd0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            busy_q  <= busy_d;
            ovf_q   <= ovf_d;
            bcnt_q  <= bcnt_d;
            ins_q   <= ins_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        // NOTE: every variable gets a hold default first, so no path can leave one
        // unassigned and infer a latch.
        state_d = state_q;
        we_d    = we_q;
        ovf_d   = ovf_q;
        bcnt_d  = bcnt_q;
        ins_d   = ins_q;
        addr_d  = addr_q;

        unique case (state_q)
            IDLE: begin
                if (bus.BUNDO)     ovf_d = 1'b0;
                else if (bus.BSTB) ovf_d = 1'b1;
                if (bus.LOAD_EN) state_d = COLLECT;
            end

            COLLECT: begin
                if (!bus.LOAD_EN) begin
                    state_d = IDLE;
                    bcnt_d  = 2'd0;
                    if (bus.BUNDO) ovf_d = 1'b0;
                end else if (bus.BUNDO) begin
                    // Undo beats a simultaneous strobe; stale bytes are simply overwritten later.
                    bcnt_d = 2'd0;
                    ovf_d  = 1'b0;
                end else if (bus.BSTB) begin
                    unique case (bcnt_q)
                        2'd0: ins_d[31:24] = bus.BIN;
                        2'd1: ins_d[23:16] = bus.BIN;
                        2'd2: ins_d[15:8]  = bus.BIN;
                        2'd3: ins_d[7:0]   = bus.BIN;
                        default: ;
                    endcase
                    bcnt_d = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd3) begin
                        state_d = WRITE;
                        we_d    = 1'b1;
                    end
                end
            end

            WRITE: begin
                if (bus.BUNDO)     ovf_d = 1'b0;
                else if (bus.BSTB) ovf_d = 1'b1;
                // The handshake always completes, even if loader mode was switched off.
                if (bus.W_ACK) begin
                    we_d    = 1'b0;
                    addr_d  = addr_q + ADDR_W'(1);
                    state_d = bus.LOAD_EN ? COLLECT : IDLE;
                end
            end

            default: state_d = IDLE;
        endcase

        busy_d = (state_d == WRITE);
    end

    assign bus.WE     = we_q;
    assign bus.BUSY   = busy_q;
    assign bus.OVF    = ovf_q;
    assign bus.BCNT   = bcnt_q;
    assign bus.W_Ins  = ins_q;
    assign bus.W_Addr = addr_q;
endmodule

// File: tb/tb_ins_loader.sv
// Bench for ins_loader: directed scenarios with literal expectations plus random
// traffic, all cross-checked every cycle against a queue-based model.
module tb_ins_loader;
    logic CLK = 1'b0;
    logic RST;

    always #5 CLK = ~CLK;

    ins_loader_if #(.ADDR_W(8)) li ();
    ins_loader_if #(.ADDR_W(2)) ln ();

    ins_loader #(.ADDR_W(8)) dut   (.CLK(CLK), .RST(RST), .bus(li.slave));
    ins_loader #(.ADDR_W(2)) dut_w (.CLK(CLK), .RST(RST), .bus(ln.slave));

    assign ln.LOAD_EN = li.LOAD_EN;
    assign ln.BIN     = li.BIN;
    assign ln.BSTB    = li.BSTB;
    assign ln.BUNDO   = li.BUNDO;
    assign ln.W_ACK   = li.W_ACK;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a mode flag, a pending-write flag and a queue of entered bytes.
    bit         m_loading;
    bit         m_writing;
    bit         m_ovf;
    logic [7:0] m_q[$];
    logic [31:0] m_word;
    logic [7:0] m_addr;

    function automatic void strobe_outside_collect();
        if (li.BUNDO)     m_ovf = 1'b0;
        else if (li.BSTB) m_ovf = 1'b1;
    endfunction

    always @(posedge CLK) begin
        if (!RST) begin
            m_loading = 0; m_writing = 0; m_ovf = 0;
            m_q.delete(); m_word = 32'd0; m_addr = 8'd0;
        end else if (m_writing) begin
            strobe_outside_collect();
            if (li.W_ACK) begin
                m_writing = 0;
                m_addr    = m_addr + 8'd1;
                m_loading = li.LOAD_EN;
            end
        end else if (!m_loading) begin
            strobe_outside_collect();
            if (li.LOAD_EN) m_loading = 1;
        end else if (!li.LOAD_EN) begin
            m_loading = 0;
            m_q.delete();
            if (li.BUNDO) m_ovf = 1'b0;
        end else if (li.BUNDO) begin
            m_q.delete();
            m_ovf = 1'b0;
        end else if (li.BSTB) begin
            m_q.push_back(li.BIN);
            if (m_q.size() == 4) begin
                m_word = {m_q[0], m_q[1], m_q[2], m_q[3]};
                m_q.delete();
                m_writing = 1;
            end
        end

        #1;
        check("we",      64'(li.WE),     64'(m_writing));
        check("busy",    64'(li.BUSY),   64'(m_writing));
        check("ovf",     64'(li.OVF),    64'(m_ovf));
        check("bcnt",    64'(li.BCNT),   64'(m_q.size()));
        check("addr",    64'(li.W_Addr), 64'(m_addr));
        if (m_writing) check("ins", 64'(li.W_Ins), 64'(m_word));
        check("n_we",    64'(ln.WE),     64'(m_writing));
        check("n_busy",  64'(ln.BUSY),   64'(m_writing));
        check("n_ovf",   64'(ln.OVF),    64'(m_ovf));
        check("n_bcnt",  64'(ln.BCNT),   64'(m_q.size()));
        check("n_addr",  64'(ln.W_Addr), 64'(m_addr[1:0]));
        if (m_writing) check("n_ins", 64'(ln.W_Ins), 64'(m_word));
    end

    // Memory-side responder: 0 = ACK tied high, 1 = ACK after ack_delay cycles, 2 = random.
    int ack_mode  = 0;
    int ack_delay = 0;
    int ack_age   = 0;

    always @(negedge CLK) begin
        case (ack_mode)
            0: li.W_ACK = 1'b1;
            1: begin
                if (li.WE) begin
                    li.W_ACK = (ack_age >= ack_delay);
                    ack_age++;
                end else begin
                    li.W_ACK = 1'b0;
                    ack_age  = 0;
                end
            end
            default: li.W_ACK = ($urandom_range(0, 2) == 0);
        endcase
    end

    // Write-pulse observer: width, stability while held, narrow-instance addresses.
    int          write_count    = 0;
    int          we_len         = 0;
    int          last_we_width  = 0;
    int          unstable       = 0;
    bit          we_prev        = 0;
    logic [31:0] held_ins;
    logic [7:0]  held_addr;
    logic [1:0]  narrow_addrs[$];

    always @(negedge CLK) begin
        if (li.WE === 1'b1) begin
            if (!we_prev) begin
                write_count++;
                narrow_addrs.push_back(ln.W_Addr);
                held_ins  = li.W_Ins;
                held_addr = li.W_Addr;
                we_len    = 0;
            end else if (li.W_Ins !== held_ins || li.W_Addr !== held_addr) begin
                unstable++;
            end
            we_len++;
            we_prev = 1;
        end else begin
            if (we_prev) last_we_width = we_len;
            we_prev = 0;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic strobe(input logic [7:0] b);
        li.BIN  = b;
        li.BSTB = 1'b1;
        @(negedge CLK);
        li.BSTB = 1'b0;
    endtask

    task automatic undo();
        li.BUNDO = 1'b1;
        @(negedge CLK);
        li.BUNDO = 1'b0;
    endtask

    task automatic word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) strobe(w[8*i +: 8]);
    endtask

    initial begin
        logic [1:0] exp_wrap[5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

        RST = 1'b0;
        li.LOAD_EN = 1'b0; li.BIN = 8'd0; li.BSTB = 1'b0; li.BUNDO = 1'b0;
        idle(2);
        check("rst_we",   64'(li.WE),     64'd0);
        check("rst_ins",  64'(li.W_Ins),  64'd0);
        check("rst_addr", 64'(li.W_Addr), 64'd0);
        check("rst_bcnt", 64'(li.BCNT),   64'd0);
        check("rst_busy", 64'(li.BUSY),   64'd0);
        check("rst_ovf",  64'(li.OVF),    64'd0);

        // Single word with ACK tied high.
        RST = 1'b1;
        li.LOAD_EN = 1'b1;
        idle(1);
        word(32'h2008_0005);
        check("t1_we",   64'(li.WE),    64'd1);
        check("t1_ins",  64'(li.W_Ins), 64'h2008_0005);
        check("t1_addr", 64'(li.W_Addr), 64'd0);
        idle(1);
        check("t1_we_fall", 64'(li.WE),     64'd0);
        check("t1_addr1",   64'(li.W_Addr), 64'd1);
        check("t1_bcnt",    64'(li.BCNT),   64'd0);
        idle(1);
        check("t1_width",   64'(last_we_width), 64'd1);

        // ACK delayed 3 cycles with a stray strobe during the write.
        ack_mode = 1; ack_delay = 3;
        word(32'h1234_5678);
        strobe(8'h99);
        check("t2_ovf_set", 64'(li.OVF), 64'd1);
        idle(6);
        check("t2_width",   64'(last_we_width), 64'd4);
        check("t2_stable",  64'(unstable),      64'd0);
        check("t2_addr",    64'(li.W_Addr),     64'd2);
        undo();
        check("t2_ovf_clr", 64'(li.OVF), 64'd0);

        // Undo, then a full word, then strobe+undo together.
        ack_delay = 0;
        strobe(8'h01); strobe(8'h02);
        check("t3_bcnt2", 64'(li.BCNT), 64'd2);
        undo();
        check("t3_bcnt0", 64'(li.BCNT), 64'd0);
        word(32'hAABB_CCDD);
        check("t3_ins", 64'(li.W_Ins), 64'hAABB_CCDD);
        idle(3);
        li.BSTB = 1'b1; li.BUNDO = 1'b1;
        @(negedge CLK);
        li.BSTB = 1'b0; li.BUNDO = 1'b0;
        check("t3_both_bcnt", 64'(li.BCNT), 64'd0);
        check("t3_both_ovf",  64'(li.OVF),  64'd0);

        // Mode exit while collecting and while writing.
        strobe(8'h0A); strobe(8'h0B); strobe(8'h0C);
        check("t4_bcnt3", 64'(li.BCNT), 64'd3);
        li.LOAD_EN = 1'b0;
        idle(1);
        check("t4_bcnt0", 64'(li.BCNT), 64'd0);
        idle(2);
        check("t4_nowe",   64'(li.WE),       64'd0);
        check("t4_writes", 64'(write_count), 64'd3);
        li.LOAD_EN = 1'b1;
        idle(1);
        ack_delay = 2;
        word(32'hDEAD_BEEF);
        li.LOAD_EN = 1'b0;
        idle(1);
        check("t4_hold", 64'(li.WE), 64'd1);
        idle(4);
        check("t4_done_we",   64'(li.WE),     64'd0);
        check("t4_done_busy", 64'(li.BUSY),   64'd0);
        check("t4_done_addr", 64'(li.W_Addr), 64'd4);
        strobe(8'h00);
        check("t4_idle_ovf", 64'(li.OVF), 64'd1);
        undo();
        li.LOAD_EN = 1'b1;
        idle(1);
        check("t4_retained", 64'(li.W_Addr), 64'd4);

        // Fifth word wraps the 2-bit address.
        word(32'h0102_0304);
        idle(4);
        check("t5_writes", 64'(write_count), 64'd5);
        for (int i = 0; i < 5; i++) check($sformatf("t5_wrap%0d", i), 64'(narrow_addrs[i]), 64'(exp_wrap[i]));

        // Random traffic against the model.
        ack_mode = 2;
        for (int i = 0; i < 400; i++) begin
            li.LOAD_EN = ($urandom_range(0, 15) != 0);
            li.BSTB    = ($urandom_range(0, 2) == 0);
            li.BUNDO   = ($urandom_range(0, 11) == 0);
            li.BIN     = 8'($urandom);
            @(negedge CLK);
        end
        li.BSTB = 1'b0; li.BUNDO = 1'b0; li.LOAD_EN = 1'b1;

        // Reset in the middle of a held write.
        ack_mode = 1; ack_delay = 0;
        idle(3);
        undo();
        ack_delay = 5;
        word(32'hCAFE_F00D);
        strobe(8'h77);
        check("t6_we",  64'(li.WE),  64'd1);
        check("t6_ovf", 64'(li.OVF), 64'd1);
        RST = 1'b0;
        idle(1);
        check("t6_rst_we",   64'(li.WE),     64'd0);
        check("t6_rst_addr", 64'(li.W_Addr), 64'd0);
        check("t6_rst_ovf",  64'(li.OVF),    64'd0);
        check("t6_rst_busy", 64'(li.BUSY),   64'd0);
        RST = 1'b1;
        idle(3);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
